// File: rtl/uart_frame_loader.sv
// Framed UART program loader: SYNC|ADDR|COUNT|PAYLOAD|CSUM frames become ready/valid memory writes.
// Define PROG_ACK_EN to answer every finished frame with ACK (06h) or NAK (15h) on programmer_tx.

module uart_engine #(
    parameter int CPB_W = 32
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic [CPB_W-1:0] cpb_i,
    input  logic             rx_i,
    output logic [7:0]       data_o,
    output logic             data_valid_o,
    input  logic             start_i,
    input  logic [7:0]       data_i,
    output logic             tx_o,
    output logic             data_sent_o
);
    logic [1:0]       rx_sync_q;
    logic             rx_busy_q;
    logic [CPB_W-1:0] rx_cnt_q;
    logic [3:0]       rx_bit_q;
    logic [7:0]       rx_sh_q;
    logic             rx_valid_q;
    logic             rx_s;
    logic [CPB_W-1:0] rx_limit;

    logic             tx_busy_q;
    logic [CPB_W-1:0] tx_cnt_q;
    logic [3:0]       tx_bit_q;
    logic [9:0]       tx_sh_q;
    logic             tx_sent_q;

    assign rx_s = rx_sync_q[1];
    // Start bit is re-checked at mid-bit; every later bit is sampled one full bit time after that.
    assign rx_limit = (rx_bit_q == 4'd0) ? (cpb_i >> 1) : (cpb_i - CPB_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rx_sync_q  <= 2'b11;
            rx_busy_q  <= 1'b0;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], rx_i};
            rx_valid_q <= 1'b0;
            if (!rx_busy_q) begin
                if (!rx_s) begin
                    rx_busy_q <= 1'b1;
                    rx_cnt_q  <= '0;
                    rx_bit_q  <= '0;
                end
            end else if (rx_cnt_q != rx_limit) begin
                rx_cnt_q <= rx_cnt_q + CPB_W'(1);
            end else begin
                rx_cnt_q <= '0;
                rx_bit_q <= rx_bit_q + 4'd1;
                if (rx_bit_q == 4'd0) begin
                    if (rx_s) rx_busy_q <= 1'b0;
                end else if (rx_bit_q == 4'd9) begin
                    rx_busy_q  <= 1'b0;
                    rx_valid_q <= rx_s;
                end else begin
                    rx_sh_q <= {rx_s, rx_sh_q[7:1]};
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            tx_busy_q <= 1'b0;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            tx_sh_q   <= '1;
            tx_sent_q <= 1'b0;
        end else begin
            tx_sent_q <= 1'b0;
            if (!tx_busy_q) begin
                if (start_i) begin
                    tx_busy_q <= 1'b1;
                    tx_cnt_q  <= '0;
                    tx_bit_q  <= '0;
                    tx_sh_q   <= {1'b1, data_i, 1'b0};
                end
            end else if (tx_cnt_q != cpb_i - CPB_W'(1)) begin
                tx_cnt_q <= tx_cnt_q + CPB_W'(1);
            end else begin
                tx_cnt_q <= '0;
                tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
                tx_bit_q <= tx_bit_q + 4'd1;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                    tx_sent_q <= 1'b1;
                end
            end
        end
    end

    assign data_o       = rx_sh_q;
    assign data_valid_o = rx_valid_q;
    assign tx_o         = tx_sh_q[0];
    assign data_sent_o  = tx_sent_q;
endmodule

module uart_frame_loader #(
    parameter int         FREQ_HZ      = 50_000_000,
    parameter int         BAUD_RATE    = 115200,
    parameter int         DATA_W       = 32,
    parameter int         ADDR_W       = 32,
    parameter int         ADDR_INC     = DATA_W / 8,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_BITS = 32
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              programmer_enable_i,
    input  logic              programmer_rx,
    output logic              programmer_tx,
    output logic              mem_write_enable_o,
    input  logic              mem_write_ready_i,
    output logic [ADDR_W-1:0] mem_write_addr_o,
    output logic [DATA_W-1:0] mem_write_data_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              frame_error_o,
    output logic [1:0]        error_code_o
);
    localparam int CPB         = FREQ_HZ / BAUD_RATE;
    localparam int TIMEOUT_CYC = TIMEOUT_BITS * CPB;
    localparam int ADDR_BYTES  = ADDR_W / 8;
    localparam int WORD_BYTES  = DATA_W / 8;
    localparam int MAX_BYTES   = (ADDR_BYTES > WORD_BYTES) ? ADDR_BYTES : WORD_BYTES;
    localparam int IDX_W       = (MAX_BYTES > 2) ? $clog2(MAX_BYTES) : 1;
    localparam int TMR_W       = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_COUNT, S_DATA, S_CSUM, S_RESP} state_e;
    typedef enum logic [1:0] {ERR_NONE, ERR_CSUM, ERR_TIMEOUT, ERR_OVERRUN} err_e;

`ifdef PROG_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif
    localparam state_e END_ST = ACK_EN ? S_RESP : S_IDLE;

    state_e            state_q, state_d;
    err_e              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] data_q, data_d, wr_data_q, wr_data_d;
    logic [15:0]       count_q, count_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        csum_q, csum_d, tx_data_q, tx_data_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              wr_en_q, wr_en_d, done_q, done_d, fail_q, fail_d, tx_start_q, tx_start_d;

    logic [7:0]        rx_byte, csum_next, eng_data;
    logic              rx_valid, eng_start, eng_tx, eng_sent, frame_active;
    logic [ADDR_W-1:0] addr_shift;
    logic [DATA_W-1:0] data_shift;

    uart_engine #(.CPB_W(32)) u_engine (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .cpb_i        (32'(CPB)),
        .rx_i         (programmer_rx),
        .data_o       (rx_byte),
        .data_valid_o (rx_valid),
        .start_i      (eng_start),
        .data_i       (eng_data),
        .tx_o         (eng_tx),
        .data_sent_o  (eng_sent)
    );

`ifdef PROG_ACK_EN
    assign eng_start     = tx_start_q;
    assign eng_data      = tx_data_q;
    assign programmer_tx = eng_tx;
`else
    logic unused_tx;
    assign unused_tx     = ^{eng_tx, tx_start_q, tx_data_q};
    assign eng_start     = 1'b0;
    assign eng_data      = 8'h00;
    assign programmer_tx = 1'b1;
`endif

    // Little-endian fields: each new byte enters at the top and older bytes move down.
    assign addr_shift   = (addr_q >> 8) | (ADDR_W'(rx_byte) << (ADDR_W - 8));
    assign data_shift   = (data_q >> 8) | (DATA_W'(rx_byte) << (DATA_W - 8));
    assign csum_next    = csum_q + rx_byte;
    assign frame_active = (state_q == S_ADDR) || (state_q == S_COUNT) ||
                          (state_q == S_DATA) || (state_q == S_CSUM);

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        state_d    = state_q;
        err_d      = err_q;
        addr_d     = addr_q;
        data_d     = data_q;
        count_d    = count_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        tmr_d      = '0;
        wr_en_d    = wr_en_q & ~mem_write_ready_i;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        fail_d     = 1'b0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;

        if (frame_active && !programmer_enable_i) begin
            state_d = S_IDLE;
        end else if (frame_active && !rx_valid && tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
            state_d = END_ST;
            err_d   = ERR_TIMEOUT;
            fail_d  = 1'b1;
        end else begin
            if (frame_active && !rx_valid) tmr_d = tmr_q + TMR_W'(1);
            unique case (state_q)
                S_IDLE: begin
                    if (programmer_enable_i && rx_valid && rx_byte == SYNC_BYTE) begin
                        state_d = S_ADDR;
                        idx_d   = '0;
                        csum_d  = '0;
                        err_d   = ERR_NONE;
                    end
                end
                S_ADDR: begin
                    if (rx_valid) begin
                        addr_d = addr_shift;
                        csum_d = csum_next;
                        idx_d  = idx_q + IDX_W'(1);
                        if (idx_q == IDX_W'(ADDR_BYTES - 1)) begin
                            idx_d   = '0;
                            state_d = S_COUNT;
                        end
                    end
                end
                S_COUNT: begin
                    if (rx_valid) begin
                        count_d = {rx_byte, count_q[15:8]};
                        csum_d  = csum_next;
                        idx_d   = idx_q + IDX_W'(1);
                        if (idx_q == IDX_W'(1)) begin
                            idx_d   = '0;
                            state_d = ({rx_byte, count_q[15:8]} == 16'd0) ? S_CSUM : S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        data_d = data_shift;
                        csum_d = csum_next;
                        idx_d  = idx_q + IDX_W'(1);
                        if (idx_q == IDX_W'(WORD_BYTES - 1)) begin
                            idx_d = '0;
                            // Only one word may wait; a second one finishing behind it is an overrun.
                            if (wr_en_q && !mem_write_ready_i) begin
                                state_d = END_ST;
                                err_d   = ERR_OVERRUN;
                                fail_d  = 1'b1;
                            end else begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = addr_q;
                                wr_data_d = data_shift;
                                addr_d    = addr_q + ADDR_W'(ADDR_INC);
                                count_d   = count_q - 16'd1;
                                if (count_q == 16'd1) state_d = S_CSUM;
                            end
                        end
                    end
                end
                S_CSUM: begin
                    if (rx_valid) begin
                        state_d = END_ST;
                        if (csum_next == 8'h00) begin
                            done_d = 1'b1;
                            err_d  = ERR_NONE;
                        end else begin
                            fail_d = 1'b1;
                            err_d  = ERR_CSUM;
                        end
                    end
                end
                S_RESP: begin
                    if (eng_sent) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (ACK_EN && (done_d || fail_d)) begin
            tx_start_d = 1'b1;
            tx_data_d  = done_d ? 8'h06 : 8'h15;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= S_IDLE;
            err_q      <= ERR_NONE;
            addr_q     <= '0;
            data_q     <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            csum_q     <= '0;
            tmr_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            tmr_q      <= tmr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign mem_write_enable_o = wr_en_q;
    assign mem_write_addr_o   = wr_addr_q;
    assign mem_write_data_o   = wr_data_q;
    assign busy_o             = (state_q != S_IDLE);
    assign frame_done_o       = done_q;
    assign frame_error_o      = fail_q;
    assign error_code_o       = err_q;
endmodule
